// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory interface stage.
// The I/O page address is only decoded when LC3_MEM_IOPAGE_EN is defined.
package lc3_mem_pkg;

   localparam int          LC3_DATA_W  = 16;
   localparam int          WAIT_CNT_W  = 4;
   localparam logic [15:0] IOPAGE_ADDR = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      RD_ACCESS,
      WR_ACCESS,
      DONE
   } mem_state_t;

endpackage

// File: rtl/lc3_wait_counter.sv
// Wait-state counter: steps from 0 up to a terminal value while enabled, flags
// the terminal count and wraps back to 0 on the step that leaves it.
module lc3_wait_counter
   import lc3_mem_pkg::*;
#(
   parameter int CNT_W = WAIT_CNT_W
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] last,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   assign tc = (count == last);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR stage driving a synchronous-strobe SRAM with fixed wait states.
// Optional I/O page at 16'hFFFF (Switches/HexOut) enabled by LC3_MEM_IOPAGE_EN.
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DATA_W      = LC3_DATA_W
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Bus,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              Req,
   input  logic              R_W,
   input  logic [DATA_W-1:0] Data_from_SRAM,
   output logic [DATA_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic [DATA_W-1:0] Data_to_SRAM,
   output logic              CE_N,
   output logic              OE_N,
   output logic              WE_N,
   output logic              R,
   output logic              Busy
`ifdef LC3_MEM_IOPAGE_EN
   ,
   input  logic [DATA_W-1:0] Switches,
   output logic [DATA_W-1:0] HexOut
`endif
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

   mem_state_t state;
   logic       waitEn;
   logic       waitTc;
   logic       ioMask;

   assign Data_to_SRAM = MDR;
   assign waitEn       = (state == RD_ACCESS) || (state == WR_ACCESS);

   lc3_wait_counter #(
      .CNT_W (WAIT_CNT_W)
   ) u_wait (
      .clock (Clk),
      .reset (Reset),
      .en    (waitEn),
      .last  (WAIT_LAST),
      .tc    (waitTc)
   );

   // The strobe decision uses the address the access will see, including a MAR load in the same cycle.
`ifdef LC3_MEM_IOPAGE_EN
   logic [DATA_W-1:0] addrNext;
   assign addrNext = LD_MAR ? Bus : MAR;
   assign ioMask   = (addrNext == DATA_W'(IOPAGE_ADDR));
`else
   assign ioMask   = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         MAR   <= '0;
         MDR   <= '0;
         CE_N  <= 1'b1;
         OE_N  <= 1'b1;
         WE_N  <= 1'b1;
         R     <= 1'b0;
         Busy  <= 1'b0;
`ifdef LC3_MEM_IOPAGE_EN
         HexOut <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (LD_MAR) MAR <= Bus;
               if (LD_MDR) MDR <= Bus;
               if (Req) begin
                  state <= R_W ? WR_ACCESS : RD_ACCESS;
                  Busy  <= 1'b1;
                  CE_N  <= ioMask;
                  OE_N  <= R_W | ioMask;
                  WE_N  <= ~R_W | ioMask;
               end
            end
            RD_ACCESS: begin
               if (waitTc) begin
                  state <= DONE;
                  R     <= 1'b1;
                  CE_N  <= 1'b1;
                  OE_N  <= 1'b1;
`ifdef LC3_MEM_IOPAGE_EN
                  MDR   <= (MAR == DATA_W'(IOPAGE_ADDR)) ? Switches : Data_from_SRAM;
`else
                  MDR   <= Data_from_SRAM;
`endif
               end
            end
            WR_ACCESS: begin
               if (waitTc) begin
                  state <= DONE;
                  R     <= 1'b1;
                  CE_N  <= 1'b1;
                  WE_N  <= 1'b1;
`ifdef LC3_MEM_IOPAGE_EN
                  if (MAR == DATA_W'(IOPAGE_ADDR)) HexOut <= MDR;
`endif
               end
            end
            DONE: begin
               state <= IDLE;
               R     <= 1'b0;
               Busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
